// File: rtl/mips_decode_alu_unit_if.sv
// Bus between the decode/ALU core and the surrounding pipeline.
// The slave modport is the core's view; the master modport is the pipeline's view.
interface mips_decode_alu_unit_if #(
    parameter int DATA_W = 32
);
    logic [31:0]       instr;
    logic [DATA_W-1:0] pc;
    logic [DATA_W-1:0] src_a;
    logic [DATA_W-1:0] src_b;
    logic [2:0]        alu_ctrl;
    logic [DATA_W-1:0] pc_plus4;
    logic              reg_dst;
    logic              jump;
    logic              branch;
    logic              mem_read;
    logic              mem_to_reg;
    logic              reg_write;
    logic              alu_src;
    logic              mem_write;
    logic [2:0]        alu_control_d;
    logic              illegal;
    logic [DATA_W-1:0] alu_result;
    logic              zero;
    logic [DATA_W-1:0] alu_result_q;
    logic              zero_q;

    modport master (
        output instr, pc, src_a, src_b, alu_ctrl,
        input  pc_plus4, reg_dst, jump, branch, mem_read, mem_to_reg, reg_write,
               alu_src, mem_write, alu_control_d, illegal, alu_result, zero,
               alu_result_q, zero_q
    );

    modport slave (
        input  instr, pc, src_a, src_b, alu_ctrl,
        output pc_plus4, reg_dst, jump, branch, mem_read, mem_to_reg, reg_write,
               alu_src, mem_write, alu_control_d, illegal, alu_result, zero,
               alu_result_q, zero_q
    );
endinterface

// File: rtl/mips_decode_alu_unit.sv
// MIPS main/ALU-control decoder, PC+4 incrementer and 3-bit ALU with a registered result.
// Optional macro ALU_NOR_EN adds the NOR operation (alu_ctrl 100, R-type funct 100111).
module mips_decode_alu_unit #(
    parameter int DATA_W = 32
) (
    input logic                  clk,
    input logic                  rst_n,
    mips_decode_alu_unit_if.slave bus
);
    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_NOR = 3'b100;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_SLT = 3'b111;

    logic [5:0] opcode;
    logic [5:0] funct;
    logic       unused_instr_bits;

    assign opcode            = bus.instr[31:26];
    assign funct             = bus.instr[5:0];
    assign unused_instr_bits = &{1'b0, bus.instr[25:6]};

    assign bus.pc_plus4 = bus.pc + DATA_W'(4);

    // Control vector order: reg_dst, jump, branch, mem_read, mem_to_reg, reg_write, alu_src, mem_write
    logic [7:0] ctl;
    assign {bus.reg_dst, bus.jump, bus.branch, bus.mem_read,
            bus.mem_to_reg, bus.reg_write, bus.alu_src, bus.mem_write} = ctl;

    always_comb begin
        ctl               = 8'b0;
        bus.alu_control_d = ALU_ADD;
        bus.illegal       = 1'b0;
        unique case (opcode)
            6'b000000: begin
                ctl = 8'b1000_0100;
                unique case (funct)
                    6'b100000: bus.alu_control_d = ALU_ADD;
                    6'b100010: bus.alu_control_d = ALU_SUB;
                    6'b100100: bus.alu_control_d = ALU_AND;
                    6'b100101: bus.alu_control_d = ALU_OR;
                    6'b101010: bus.alu_control_d = ALU_SLT;
`ifdef ALU_NOR_EN
                    6'b100111: bus.alu_control_d = ALU_NOR;
`endif
                    default: begin
                        // Unknown funct keeps reg_dst but must not write the register file
                        ctl         = 8'b1000_0000;
                        bus.illegal = 1'b1;
                    end
                endcase
            end
            6'b100011: ctl = 8'b0001_1110;
            6'b101011: ctl = 8'b0000_0011;
            6'b000100: begin
                ctl               = 8'b0010_0000;
                bus.alu_control_d = ALU_SUB;
            end
            6'b001000: ctl = 8'b0000_0110;
            6'b000010: ctl = 8'b0100_0000;
            default:   bus.illegal = 1'b1;
        endcase
    end

    always_comb begin
        bus.alu_result = '0;
        unique case (bus.alu_ctrl)
            ALU_ADD: bus.alu_result = bus.src_a + bus.src_b;
            ALU_SUB: bus.alu_result = bus.src_a - bus.src_b;
            ALU_AND: bus.alu_result = bus.src_a & bus.src_b;
            ALU_OR:  bus.alu_result = bus.src_a | bus.src_b;
            ALU_SLT: bus.alu_result = DATA_W'($signed(bus.src_a) < $signed(bus.src_b));
`ifdef ALU_NOR_EN
            ALU_NOR: bus.alu_result = ~(bus.src_a | bus.src_b);
`endif
            default: bus.alu_result = '0;
        endcase
    end

    assign bus.zero = (bus.alu_result == '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.alu_result_q <= '0;
            bus.zero_q       <= 1'b0;
        end else begin
            bus.alu_result_q <= bus.alu_result;
            bus.zero_q       <= bus.zero;
        end
    end
endmodule

// File: tb/tb_mips_decode_alu_unit.sv
// Directed bench for mips_decode_alu_unit: vector table for decode/PC/ALU plus reset sequences.
module tb_mips_decode_alu_unit;
    localparam int DATA_W = 32;

    logic clk = 1'b0;
    logic rst_n;
    int   n_checks = 0;
    int   n_fail   = 0;

    mips_decode_alu_unit_if #(.DATA_W(DATA_W)) bus ();

    mips_decode_alu_unit #(.DATA_W(DATA_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] instr;
        logic [31:0] pc;
        logic [31:0] a;
        logic [31:0] b;
        logic [2:0]  ctrl;
        logic [31:0] exp_pc4;
        logic [7:0]  exp_ctl;
        logic [2:0]  exp_aluc;
        logic        exp_ill;
        logic [31:0] exp_res;
        logic        exp_zero;
    } vec_t;

    vec_t vecs[13];

    function automatic vec_t mk(logic [31:0] instr, logic [31:0] pc, logic [31:0] a,
                                logic [31:0] b, logic [2:0] ctrl, logic [31:0] exp_pc4,
                                logic [7:0] exp_ctl, logic [2:0] exp_aluc, logic exp_ill,
                                logic [31:0] exp_res, logic exp_zero);
        vec_t v;
        v.instr = instr; v.pc = pc; v.a = a; v.b = b; v.ctrl = ctrl;
        v.exp_pc4 = exp_pc4; v.exp_ctl = exp_ctl; v.exp_aluc = exp_aluc;
        v.exp_ill = exp_ill; v.exp_res = exp_res; v.exp_zero = exp_zero;
        return v;
    endfunction

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    logic [7:0] ctl_act;
    assign ctl_act = {bus.reg_dst, bus.jump, bus.branch, bus.mem_read,
                      bus.mem_to_reg, bus.reg_write, bus.alu_src, bus.mem_write};

    initial begin
        vecs[0]  = mk(32'h8C220004, 32'h00400000, 32'd5, 32'd7, 3'b010,
                      32'h00400004, 8'b0001_1110, 3'b010, 1'b0, 32'd12, 1'b0);
        vecs[1]  = mk(32'hAC220004, 32'hFFFFFFFC, 32'd5, 32'd7, 3'b110,
                      32'h00000000, 8'b0000_0011, 3'b010, 1'b0, 32'hFFFFFFFE, 1'b0);
        vecs[2]  = mk(32'h00221822, 32'h00000010, 32'h80000000, 32'h7FFFFFFF, 3'b111,
                      32'h00000014, 8'b1000_0100, 3'b110, 1'b0, 32'd1, 1'b0);
        vecs[3]  = mk(32'h00221820, 32'h7FFFFFFE, 32'd3, 32'd3, 3'b111,
                      32'h80000002, 8'b1000_0100, 3'b010, 1'b0, 32'd0, 1'b1);
        vecs[4]  = mk(32'h00221824, 32'h00000000, 32'h0000F0F0, 32'h0000FF00, 3'b000,
                      32'h00000004, 8'b1000_0100, 3'b000, 1'b0, 32'h0000F000, 1'b0);
        vecs[5]  = mk(32'h00221825, 32'h00001000, 32'h0000F0F0, 32'h0000FF00, 3'b001,
                      32'h00001004, 8'b1000_0100, 3'b001, 1'b0, 32'h0000FFF0, 1'b0);
        vecs[6]  = mk(32'h0022182A, 32'h00000020, 32'h7FFFFFFF, 32'h80000000, 3'b111,
                      32'h00000024, 8'b1000_0100, 3'b111, 1'b0, 32'd0, 1'b1);
        vecs[7]  = mk(32'h10220003, 32'h00000030, 32'd3, 32'd3, 3'b110,
                      32'h00000034, 8'b0010_0000, 3'b110, 1'b0, 32'd0, 1'b1);
        vecs[8]  = mk(32'h20220005, 32'h00000040, 32'hFFFFFFFF, 32'd1, 3'b010,
                      32'h00000044, 8'b0000_0110, 3'b010, 1'b0, 32'd0, 1'b1);
        vecs[9]  = mk(32'h08000010, 32'h00000050, 32'd5, 32'd7, 3'b011,
                      32'h00000054, 8'b0100_0000, 3'b010, 1'b0, 32'd0, 1'b1);
        vecs[10] = mk(32'hFC000000, 32'h00000060, 32'd5, 32'd7, 3'b101,
                      32'h00000064, 8'b0000_0000, 3'b010, 1'b1, 32'd0, 1'b1);
`ifdef ALU_NOR_EN
        vecs[11] = mk(32'h00221827, 32'h00000070, 32'd0, 32'd0, 3'b100,
                      32'h00000074, 8'b1000_0100, 3'b100, 1'b0, 32'hFFFFFFFF, 1'b0);
`else
        vecs[11] = mk(32'h00221827, 32'h00000070, 32'd0, 32'd0, 3'b100,
                      32'h00000074, 8'b1000_0000, 3'b010, 1'b1, 32'd0, 1'b1);
`endif
        vecs[12] = mk(32'h00221800, 32'h00000080, 32'd9, 32'd9, 3'b110,
                      32'h00000084, 8'b1000_0000, 3'b010, 1'b1, 32'd0, 1'b1);

        // Reset held: comb path live, register cleared
        rst_n = 1'b0;
        bus.instr = 32'h00221820; bus.pc = 32'h0; bus.src_a = 32'd1; bus.src_b = 32'd2;
        bus.alu_ctrl = 3'b010;
        repeat (2) @(posedge clk);
        #1;
        check("rst_result_q", bus.alu_result_q, 32'd0);
        check("rst_zero_q", {31'b0, bus.zero_q}, 32'd0);
        check("rst_comb_result", bus.alu_result, 32'd3);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("first_capture_q", bus.alu_result_q, 32'd3);
        check("first_capture_zero_q", {31'b0, bus.zero_q}, 32'd0);
        // Asynchronous assertion mid-cycle
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst_q", bus.alu_result_q, 32'd0);
        check("async_rst_zero_q", {31'b0, bus.zero_q}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 13; i++) begin
            @(negedge clk);
            bus.instr = vecs[i].instr; bus.pc = vecs[i].pc;
            bus.src_a = vecs[i].a; bus.src_b = vecs[i].b; bus.alu_ctrl = vecs[i].ctrl;
            #1;
            check($sformatf("v%0d_pc_plus4", i), bus.pc_plus4, vecs[i].exp_pc4);
            check($sformatf("v%0d_ctl", i), {24'b0, ctl_act}, {24'b0, vecs[i].exp_ctl});
            check($sformatf("v%0d_alu_control_d", i), {29'b0, bus.alu_control_d},
                  {29'b0, vecs[i].exp_aluc});
            check($sformatf("v%0d_illegal", i), {31'b0, bus.illegal}, {31'b0, vecs[i].exp_ill});
            check($sformatf("v%0d_alu_result", i), bus.alu_result, vecs[i].exp_res);
            check($sformatf("v%0d_zero", i), {31'b0, bus.zero}, {31'b0, vecs[i].exp_zero});
            @(posedge clk);
            #1;
            check($sformatf("v%0d_alu_result_q", i), bus.alu_result_q, vecs[i].exp_res);
            check($sformatf("v%0d_zero_q", i), {31'b0, bus.zero_q}, {31'b0, vecs[i].exp_zero});
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
